// File: rtl/mem_master.sv
// mem_master: initiator side of the 4096x16 main-memory interface.
// Turns one CPU-control request (fetch / read / write) into a timed sequence
// of address, read-strobe and write-strobe cycles, optionally resolving one
// level of indirection first, and returns the result on a one-cycle strobe.
// Also owns the program counter used for instruction fetches.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_op                00 fetch, 01 read, 10 write, 11 read
//   req_addr, req_ind     operand address, resolve-indirect flag
//   req_wdata             store data
//   rsp_valid             one-cycle result strobe
//   rsp_data, rsp_addr    result data and effective address (held)
//   pc, pc_load, pc_in    program counter and its load port
//   mem_ar, mem_din       memory address / write data (held between strobes)
//   mem_we, mem_re        memory write / read strobes (one cycle each)
//   mem_dout              memory read data, valid RD_LAT cycles after mem_re
//   busy                  high whenever not IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// IND_RD | read strobe on the pointer address
// IND_WT | waiting RD_LAT cycles for the pointer word
// ACC_RD | read strobe on the effective address
// ACC_WT | waiting RD_LAT cycles for the read data
// ACC_WR | write strobe on the effective address
// RESP   | rsp_valid high for one cycle

module mem_master #(
    parameter int          RD_LAT = 1,
    parameter logic [11:0] PC_RST = 12'h000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic        req_ind,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [11:0] rsp_addr,
    output logic [11:0] pc,
    input  logic        pc_load,
    input  logic [11:0] pc_in,
    output logic [11:0] mem_ar,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_dout,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IND_RD = 3'd1,
        IND_WT = 3'd2,
        ACC_RD = 3'd3,
        ACC_WT = 3'd4,
        ACC_WR = 3'd5,
        RESP   = 3'd6
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [2:0] LAT_M1   = 3'(RD_LAT - 1);

    state_t      state, state_nx;
    logic [1:0]  op_q, op_nx;
    logic [11:0] addr_q, addr_nx;   // pointer address, then effective address
    logic [15:0] wdata_q, wdata_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [11:0] cap_addr;

    logic        rsp_valid_nx;
    logic [15:0] rsp_data_nx;
    logic [11:0] rsp_addr_nx;
    logic [11:0] pc_nx;
    logic [11:0] mem_ar_nx;
    logic [15:0] mem_din_nx;
    logic        mem_we_nx;
    logic        mem_re_nx;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            addr_q    <= 12'h000;
            wdata_q   <= 16'h0000;
            cnt       <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_addr  <= 12'h000;
            pc        <= PC_RST;
            mem_ar    <= 12'h000;
            mem_din   <= 16'h0000;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            cnt       <= cnt_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_addr  <= rsp_addr_nx;
            pc        <= pc_nx;
            mem_ar    <= mem_ar_nx;
            mem_din   <= mem_din_nx;
            mem_we    <= mem_we_nx;
            mem_re    <= mem_re_nx;
        end
    end

    // Outputs are registered, so each strobe is decided on the edge that
    // enters its state: the strobe is high during the *_RD / ACC_WR cycle.
    always_comb begin
        state_nx     = state;
        op_nx        = op_q;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        cnt_nx       = cnt;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = rsp_data;
        rsp_addr_nx  = rsp_addr;
        pc_nx        = pc;
        mem_ar_nx    = mem_ar;
        mem_din_nx   = mem_din;
        mem_we_nx    = 1'b0;
        mem_re_nx    = 1'b0;
        cap_addr     = (req_op == OP_FETCH) ? pc : req_addr;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_nx    = req_op;
                    addr_nx  = cap_addr;
                    wdata_nx = req_wdata;
                    if (req_op != OP_FETCH && req_ind) begin
                        state_nx  = IND_RD;
                        mem_ar_nx = cap_addr;
                        mem_re_nx = 1'b1;
                    end else if (req_op == OP_WRITE) begin
                        state_nx   = ACC_WR;
                        mem_ar_nx  = cap_addr;
                        mem_din_nx = req_wdata;
                        mem_we_nx  = 1'b1;
                    end else begin
                        state_nx  = ACC_RD;
                        mem_ar_nx = cap_addr;
                        mem_re_nx = 1'b1;
                    end
                end
            end
            IND_RD: begin
                state_nx = IND_WT;
                cnt_nx   = LAT_M1;
            end
            IND_WT: begin
                if (cnt == 3'd0) begin
                    addr_nx   = mem_dout[11:0];
                    mem_ar_nx = mem_dout[11:0];
                    if (op_q == OP_WRITE) begin
                        state_nx   = ACC_WR;
                        mem_din_nx = wdata_q;
                        mem_we_nx  = 1'b1;
                    end else begin
                        state_nx  = ACC_RD;
                        mem_re_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ACC_RD: begin
                state_nx = ACC_WT;
                cnt_nx   = LAT_M1;
            end
            ACC_WT: begin
                if (cnt == 3'd0) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = mem_dout;
                    rsp_addr_nx  = addr_q;
                    if (op_q == OP_FETCH) begin
                        pc_nx = pc + 12'd1;
                    end
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ACC_WR: begin
                state_nx     = RESP;
                rsp_valid_nx = 1'b1;
                rsp_data_nx  = wdata_q;
                rsp_addr_nx  = addr_q;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // An explicit load always beats the fetch increment.
        if (pc_load) begin
            pc_nx = pc_in;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

    localparam int L  = 1;
    localparam int L3 = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        req_valid = 1'b0, req_ready, req_ind = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_addr = 12'h000, pc, pc_in = 12'h000, mem_ar, rsp_addr;
    logic [15:0] req_wdata = 16'h0000, rsp_data, mem_din, mem_dout;
    logic        rsp_valid, pc_load = 1'b0, mem_we, mem_re, busy;

    logic        req_valid3 = 1'b0, req_ready3, rsp_valid3, mem_we3, mem_re3, busy3;
    logic [11:0] req_addr3 = 12'h000, rsp_addr3, pc3, mem_ar3;
    logic [15:0] rsp_data3, mem_din3, mem_dout3;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_master #(.RD_LAT(L), .PC_RST(12'h000)) u_dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_ind(req_ind), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .pc(pc), .pc_load(pc_load), .pc_in(pc_in),
        .mem_ar(mem_ar), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout), .busy(busy)
    );

    mem_master #(.RD_LAT(L3), .PC_RST(12'h000)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(2'b01),
        .req_addr(req_addr3), .req_ind(1'b0), .req_wdata(16'h0000),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_addr(rsp_addr3),
        .pc(pc3), .pc_load(1'b0), .pc_in(12'h000),
        .mem_ar(mem_ar3), .mem_din(mem_din3), .mem_we(mem_we3), .mem_re(mem_re3),
        .mem_dout(mem_dout3), .busy(busy3)
    );

    // ---------------- memories ----------------
    logic [15:0] mem [4096];
    logic [15:0] dp  [L];
    logic [15:0] dp3 [L3];

    function automatic logic [15:0] f3(input logic [11:0] a);
        return {a[3:0], a} ^ 16'h5A5A;
    endfunction

    always @(posedge CLK) begin
        dp[0] <= mem_re ? mem[mem_ar] : 16'($urandom);
        for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
        if (mem_we) mem[mem_ar] <= mem_din;
        dp3[0] <= mem_re3 ? f3(mem_ar3) : 16'($urandom);
        for (int i = 1; i < L3; i++) dp3[i] <= dp3[i-1];
    end
    assign mem_dout  = dp[L-1];
    assign mem_dout3 = dp3[L3-1];

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A request is a fixed schedule relative to its accept edge (cycle 0):
    // optional pointer read in cycle 1, access in cycle acc, response in n.
    logic        m_idle, m_fetch, m_write, m_ind;
    int          m_t, m_n, m_acc;
    logic [11:0] m_addr, m_ea, m_pc, old_pc;
    logic [15:0] m_data, m_wdata;
    logic        e_re, e_we, e_rv, fin_fetch;
    logic [11:0] e_ar, e_ra;
    logic [15:0] e_din, e_rd;

    always @(posedge CLK) begin
        if (RST) begin
            m_idle = 1'b1; m_t = 0; m_n = 0; m_acc = 0;
            m_fetch = 1'b0; m_write = 1'b0; m_ind = 1'b0;
            m_pc = 12'h000;
            e_re = 1'b0; e_we = 1'b0; e_rv = 1'b0;
            e_ar = 12'h000; e_din = 16'h0000; e_rd = 16'h0000; e_ra = 12'h000;
        end else begin
            old_pc    = m_pc;
            fin_fetch = !m_idle && m_fetch && (m_t == m_n - 1);
            if (pc_load) m_pc = pc_in;
            else if (fin_fetch) m_pc = m_pc + 12'd1;
            if (!m_idle) begin
                if (m_t == m_n) m_idle = 1'b1;
                else m_t++;
            end else if (req_valid) begin
                m_idle  = 1'b0;
                m_t     = 1;
                m_fetch = (req_op == 2'b00);
                m_write = (req_op == 2'b10);
                m_ind   = !m_fetch && req_ind;
                m_addr  = m_fetch ? old_pc : req_addr;
                m_wdata = req_wdata;
                m_ea    = m_ind ? mem[m_addr][11:0] : m_addr;
                m_acc   = m_ind ? 2 + L : 1;
                m_n     = m_write ? m_acc + 1 : m_acc + 1 + L;
                m_data  = m_write ? m_wdata : mem[m_ea];
            end
            e_re = !m_idle && ((m_ind && m_t == 1) || (!m_write && m_t == m_acc));
            e_we = !m_idle && m_write && (m_t == m_acc);
            e_rv = !m_idle && (m_t == m_n);
            if (!m_idle && m_ind && m_t == 1) e_ar = m_addr;
            if (!m_idle && m_t == m_acc) begin
                e_ar = m_ea;
                if (m_write) e_din = m_wdata;
            end
            if (e_rv) begin
                e_rd = m_data;
                e_ra = m_ea;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_idle));
            chk("busy",      32'(busy),      32'(!m_idle));
            chk("mem_re",    32'(mem_re),    32'(e_re));
            chk("mem_we",    32'(mem_we),    32'(e_we));
            chk("mem_ar",    32'(mem_ar),    32'(e_ar));
            chk("mem_din",   32'(mem_din),   32'(e_din));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_data",  32'(rsp_data),  32'(e_rd));
            chk("rsp_addr",  32'(rsp_addr),  32'(e_ra));
            chk("pc",        32'(pc),        32'(m_pc));
        end
    end

    // ---------------- RD_LAT=3 monitor ----------------
    int          cyc = 0;
    int          acc_c[$];
    logic [11:0] acc_a[$];
    int          rsp_c[$];
    logic [15:0] rsp_d[$];

    always @(posedge CLK) begin
        if (!RST && req_valid3 && req_ready3) begin
            acc_c.push_back(cyc);
            acc_a.push_back(req_addr3);
        end
        cyc = cyc + 1;
    end

    always @(negedge CLK) begin
        if (rsp_valid3) begin
            rsp_c.push_back(cyc);
            rsp_d.push_back(rsp_data3);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_req(input logic [1:0] op, input logic [11:0] a, input logic ind,
                          input logic [15:0] wd, output int lat);
        int c;
        @(negedge CLK);
        req_op = op; req_addr = a; req_ind = ind; req_wdata = wd; req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        c = 1;
        while (!rsp_valid && c < 40) begin
            @(negedge CLK);
            c++;
        end
        lat = c;
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) if (i % 2 == 0) mem[i][11:0] = 12'($urandom_range(0, 63));
        mem[12'h000] = 16'h2005;
        mem[12'h010] = 16'h0123;
        mem[12'h123] = 16'hABCD;
        mem[12'hFFF] = 16'h7E57;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_pc",    32'(pc),        32'h000);
        chk("rst_re_we", 32'({mem_re, mem_we, rsp_valid}), 32'h0);
        RST = 1'b0;

        // fetch from reset PC; req_addr/req_ind must be ignored
        do_req(2'b00, 12'h555, 1'b1, 16'h0000, lat);
        chk("fetch_lat",  32'(lat),      32'd3);
        chk("fetch_data", 32'(rsp_data), 32'h2005);
        chk("fetch_addr", 32'(rsp_addr), 32'h000);
        chk("fetch_pc",   32'(pc),       32'h001);

        do_req(2'b10, 12'h003, 1'b0, 16'h1111, lat);
        chk("wr_lat",  32'(lat),      32'd2);
        chk("wr_data", 32'(rsp_data), 32'h1111);
        do_req(2'b01, 12'h003, 1'b0, 16'h0000, lat);
        chk("rd_lat",  32'(lat),      32'd3);
        chk("rd_data", 32'(rsp_data), 32'h1111);

        do_req(2'b01, 12'h010, 1'b1, 16'h0000, lat);
        chk("ind_lat",  32'(lat),      32'd5);
        chk("ind_data", 32'(rsp_data), 32'hABCD);
        chk("ind_addr", 32'(rsp_addr), 32'h123);

        // PC wrap
        @(negedge CLK); pc_load = 1'b1; pc_in = 12'hFFF;
        @(negedge CLK); pc_load = 1'b0;
        do_req(2'b00, 12'h000, 1'b0, 16'h0000, lat);
        chk("wrap_addr", 32'(rsp_addr), 32'hFFF);
        chk("wrap_data", 32'(rsp_data), 32'h7E57);
        chk("wrap_pc",   32'(pc),       32'h000);

        // pc_load on the increment edge wins
        @(negedge CLK); req_op = 2'b00; req_valid = 1'b1;
        @(negedge CLK); req_valid = 1'b0;
        @(negedge CLK); pc_load = 1'b1; pc_in = 12'h0AA;
        @(negedge CLK); pc_load = 1'b0;
        chk("load_win_rsp", 32'(rsp_valid), 32'h1);
        chk("load_win_pc",  32'(pc),        32'h0AA);
        @(negedge CLK);

        // reset during ACC_WT
        @(negedge CLK); req_op = 2'b01; req_addr = 12'h003; req_ind = 1'b0; req_valid = 1'b1;
        @(negedge CLK); req_valid = 1'b0;
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_re",    32'(mem_re),    32'h0);
        chk("rst_mid_pc",    32'(pc),        32'h000);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_norsp", 32'(rsp_valid), 32'h0);
            @(negedge CLK);
        end

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            req_valid = ($urandom % 3) != 0;
            req_op    = 2'($urandom);
            req_addr  = ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            req_ind   = 1'($urandom);
            req_wdata = 16'($urandom);
            pc_load   = ($urandom % 20) == 0;
            pc_in     = 12'($urandom);
            RST       = ($urandom % 300) == 0;
        end
        @(negedge CLK);
        req_valid = 1'b0; pc_load = 1'b0; RST = 1'b0;
        repeat (20) @(negedge CLK);

        // RD_LAT=3 instance, request held high
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            req_valid3 = 1'b1;
            req_addr3  = 12'($urandom);
        end
        @(negedge CLK);
        req_valid3 = 1'b0;
        repeat (12) @(negedge CLK);

        chk("lat3_acc_count", 32'(acc_c.size()), 32'd5);
        chk("lat3_rsp_count", 32'(rsp_c.size()), 32'd5);
        if (acc_c.size() == 5 && rsp_c.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("lat3_latency", 32'(rsp_c[i] - acc_c[i]), 32'd5);
                chk("lat3_data",    32'(rsp_d[i]),            32'(f3(acc_a[i])));
                if (i > 0) chk("lat3_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd6);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
